// File: rtl/multi_timer_core_if.sv
// Command bundle for multi_timer_core: channel select, load value, command strobes,
// count direction and speed. The controller drives it through master, the core reads it through slave.
interface multi_timer_core_if #(
  parameter int NUM_CH = 4
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0] ch_sel;
  logic [5:0]    time_in;
  logic          min_load;
  logic          sec_load;
  logic          start;
  logic          pause;
  logic          dir;
  logic          speed;

  modport master (
    output ch_sel, time_in, min_load, sec_load, start, pause, dir, speed
  );

  modport slave (
    input ch_sel, time_in, min_load, sec_load, start, pause, dir, speed
  );
endinterface

// File: rtl/multi_timer_core.sv
// NUM_CH independent mm:ss timers sharing one prescaler tick.
// Optional alarm auto-clear after ALARM_TICKS ticks is enabled by defining TIMER_ALARM_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | stopped, loads accepted, start begins counting
// ST_RUN    | counting on every tick in the latched direction
// ST_PAUSED | frozen, loads accepted, pause resumes
// ST_ALARM  | down count hit 00:00, held until start/load (or timeout)
module multi_timer_core #(
  parameter int NUM_CH      = 4,
  parameter int TICK_DIV    = 100_000_000,
  parameter int FAST_DIV    = 20_000_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_timer_core_if.slave     cmd,
  output logic                  tick,
  output logic [6*NUM_CH-1:0]   min_out,
  output logic [6*NUM_CH-1:0]   sec_out,
  output logic [NUM_CH-1:0]     running,
  output logic [NUM_CH-1:0]     alarm
);

  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAX_DIV = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
  localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
  localparam logic [5:0]    MAX_FIELD = 6'd59;

  if (NUM_CH < 1 || NUM_CH > 16 || ALARM_TICKS < 1) begin : g_bad_param
    $error("multi_timer_core: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  logic [PW-1:0] pre_q, pre_d, pre_last;
  logic          speed_q, speed_d;
  logic          tick_q, tick_d;

  state_t        state_q [NUM_CH];
  state_t        state_d [NUM_CH];
  logic [5:0]    mm_q    [NUM_CH];
  logic [5:0]    mm_d    [NUM_CH];
  logic [5:0]    ss_q    [NUM_CH];
  logic [5:0]    ss_d    [NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [NUM_CH-1:0] ch_hit;
  logic [5:0]        load_val;
  logic              any_load;

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  logic [AW-1:0] acnt_q [NUM_CH];
  logic [AW-1:0] acnt_d [NUM_CH];
`endif

  // A speed change restarts the count so the first tick at the new rate is a full period.
  always_comb begin
    pre_last = cmd.speed ? FAST_LAST : TICK_LAST;
    speed_d  = cmd.speed;
    if (cmd.speed != speed_q || pre_q >= pre_last) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    tick_d = (pre_d == pre_last);
  end

  always_comb begin
    ch_hit = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_hit[n] = (cmd.ch_sel == CW'(n));
    end
  end

  always_comb begin
    load_val  = (cmd.time_in > MAX_FIELD) ? MAX_FIELD : cmd.time_in;
    any_load  = cmd.min_load | cmd.sec_load;
    dir_d     = dir_q;
    running_d = '0;
    alarm_d   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      state_d[n] = state_q[n];
      mm_d[n]    = mm_q[n];
      ss_d[n]    = ss_q[n];
`ifdef TIMER_ALARM_TIMEOUT_EN
      acnt_d[n]  = acnt_q[n];
`endif
      // Any strobe addressed to this channel consumes the cycle, so its tick is dropped.
      if (ch_hit[n] && any_load) begin
        if (state_q[n] != ST_RUN) begin
          if (cmd.min_load) mm_d[n] = load_val;
          if (cmd.sec_load) ss_d[n] = load_val;
          if (state_q[n] == ST_ALARM) state_d[n] = ST_IDLE;
        end
      end else if (ch_hit[n] && cmd.start) begin
        case (state_q[n])
          ST_IDLE: begin
            dir_d[n] = cmd.dir;
            if (!cmd.dir && mm_q[n] == 6'd0 && ss_q[n] == 6'd0) begin
              state_d[n] = ST_ALARM;
            end else begin
              state_d[n] = ST_RUN;
            end
          end
          ST_ALARM: state_d[n] = ST_IDLE;
          default:  state_d[n] = state_q[n];
        endcase
      end else if (ch_hit[n] && cmd.pause) begin
        if (state_q[n] == ST_RUN) begin
          state_d[n] = ST_PAUSED;
        end else if (state_q[n] == ST_PAUSED) begin
          state_d[n] = ST_RUN;
        end
      end else if (tick_q) begin
        if (state_q[n] == ST_RUN) begin
          if (dir_q[n]) begin
            if (ss_q[n] == MAX_FIELD) begin
              ss_d[n] = 6'd0;
              mm_d[n] = (mm_q[n] == MAX_FIELD) ? 6'd0 : mm_q[n] + 6'd1;
            end else begin
              ss_d[n] = ss_q[n] + 6'd1;
            end
          end else if (mm_q[n] == 6'd0 && ss_q[n] == 6'd0) begin
            // Resumed from pause after a 00:00 load: alarm rather than underflow.
            state_d[n] = ST_ALARM;
          end else begin
            if (ss_q[n] == 6'd0) begin
              ss_d[n] = MAX_FIELD;
              mm_d[n] = mm_q[n] - 6'd1;
            end else begin
              ss_d[n] = ss_q[n] - 6'd1;
            end
            if (mm_q[n] == 6'd0 && ss_q[n] == 6'd1) state_d[n] = ST_ALARM;
          end
        end
`ifdef TIMER_ALARM_TIMEOUT_EN
        else if (state_q[n] == ST_ALARM) begin
          if (acnt_q[n] == ALARM_LAST) begin
            state_d[n] = ST_IDLE;
            mm_d[n]    = 6'd0;
            ss_d[n]    = 6'd0;
          end else begin
            acnt_d[n] = acnt_q[n] + 1'b1;
          end
        end
`endif
      end
`ifdef TIMER_ALARM_TIMEOUT_EN
      // Held at zero outside ALARM so every alarm entry starts a fresh count.
      if (state_d[n] != ST_ALARM) acnt_d[n] = '0;
`endif
      running_d[n] = (state_d[n] == ST_RUN);
      alarm_d[n]   = (state_d[n] == ST_ALARM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q     <= '0;
      speed_q   <= 1'b0;
      tick_q    <= 1'b0;
      dir_q     <= '0;
      running_q <= '0;
      alarm_q   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n] <= ST_IDLE;
        mm_q[n]    <= 6'd0;
        ss_q[n]    <= 6'd0;
`ifdef TIMER_ALARM_TIMEOUT_EN
        acnt_q[n]  <= '0;
`endif
      end
    end else begin
      pre_q     <= pre_d;
      speed_q   <= speed_d;
      tick_q    <= tick_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n] <= state_d[n];
        mm_q[n]    <= mm_d[n];
        ss_q[n]    <= ss_d[n];
`ifdef TIMER_ALARM_TIMEOUT_EN
        acnt_q[n]  <= acnt_d[n];
`endif
      end
    end
  end

  always_comb begin
    min_out = '0;
    sec_out = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      min_out[6*n +: 6] = mm_q[n];
      sec_out[6*n +: 6] = ss_q[n];
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_multi_timer_core.sv
// Directed bench for multi_timer_core with NUM_CH=4, TICK_DIV=10, FAST_DIV=2, ALARM_TICKS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_timer_core;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick;
  logic [6*NUM_CH-1:0] min_out, sec_out;
  logic [NUM_CH-1:0] running, alarm;
  int vectors = 0;
  int miscompares = 0;

  multi_timer_core_if #(.NUM_CH(NUM_CH)) cmd_if ();

  multi_timer_core #(
    .NUM_CH(NUM_CH), .TICK_DIV(10), .FAST_DIV(2), .ALARM_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .tick(tick),
    .min_out(min_out), .sec_out(sec_out), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] secf(input int ch);
    return sec_out[6*ch +: 6];
  endfunction

  function automatic logic [5:0] minf(input int ch);
    return min_out[6*ch +: 6];
  endfunction

  // Returns at the falling edge of a cycle in which tick is high (the current one if already high).
  task automatic wait_tick;
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tick !== 1'b1) begin
      $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
      miscompares++;
    end
  endtask

  // One-cycle command strobe; returns at the falling edge where its effect is visible.
  task automatic pulse(input int ch, input bit ml, input bit sl, input bit st,
                       input bit pa, input logic [5:0] v, input bit d);
    cmd_if.ch_sel   = 2'(ch);
    cmd_if.time_in  = v;
    cmd_if.min_load = ml;
    cmd_if.sec_load = sl;
    cmd_if.start    = st;
    cmd_if.pause    = pa;
    cmd_if.dir      = d;
    @(negedge clk);
    cmd_if.min_load = 1'b0;
    cmd_if.sec_load = 1'b0;
    cmd_if.start    = 1'b0;
    cmd_if.pause    = 1'b0;
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (min_out !== '0 || sec_out !== '0) begin
      $display("FAIL rst_value: min=%h sec=%h, required 0", min_out, sec_out); miscompares++;
    end
    vectors++;
    if (running !== '0 || alarm !== '0 || tick !== 1'b0) begin
      $display("FAIL rst_flags: run=%b alarm=%b tick=%b, required 0", running, alarm, tick);
      miscompares++;
    end
    rst = 1'b1;
    cyc = 1;
    while (tick !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != 10) begin
      $display("FAIL rst_first_tick: tick in cycle %0d after release, required 10", cyc);
      miscompares++;
    end
  endtask

  task automatic test_down_count;
    wait_tick; @(negedge clk);
    pulse(2, 0, 1, 0, 0, 6'd3, 0);
    vectors++;
    if (secf(2) !== 6'd3) begin
      $display("FAIL dc_load: sec2=%0d, required 3", secf(2)); miscompares++;
    end
    pulse(2, 0, 0, 1, 0, 6'd0, 0);
    vectors++;
    if (running !== 4'b0100) begin
      $display("FAIL dc_start: running=%b, required 0100", running); miscompares++;
    end
    for (int k = 2; k >= 0; k--) begin
      wait_tick; @(negedge clk);
      vectors++;
      if (secf(2) !== k[5:0]) begin
        $display("FAIL dc_step: sec2=%0d, required %0d", secf(2), k); miscompares++;
      end
    end
    vectors++;
    if (alarm !== 4'b0100 || running !== 4'b0000) begin
      $display("FAIL dc_alarm: alarm=%b running=%b, required 0100/0000", alarm, running);
      miscompares++;
    end
    vectors++;
    if (min_out !== '0 || sec_out !== '0) begin
      $display("FAIL dc_others: min=%h sec=%h, required 0", min_out, sec_out); miscompares++;
    end
  endtask

  task automatic test_alarm_hold;
`ifdef TIMER_ALARM_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      wait_tick; @(negedge clk);
      vectors++;
      if (alarm[2] !== (k < 3)) begin
        $display("FAIL alarm_timeout: alarm2=%b after %0d ticks, required %b", alarm[2], k, (k < 3));
        miscompares++;
      end
    end
    vectors++;
    if (minf(2) !== 6'd0 || secf(2) !== 6'd0 || running[2] !== 1'b0) begin
      $display("FAIL alarm_timeout_val: %0d:%0d run=%b, required 0:0 run=0", minf(2), secf(2), running[2]);
      miscompares++;
    end
`else
    repeat (20) begin
      wait_tick; @(negedge clk);
    end
    vectors++;
    if (alarm[2] !== 1'b1) begin
      $display("FAIL alarm_held: alarm2=%b after 20 ticks, required 1", alarm[2]); miscompares++;
    end
    pulse(2, 0, 0, 1, 0, 6'd0, 0);
    vectors++;
    if (alarm[2] !== 1'b0 || running[2] !== 1'b0 || secf(2) !== 6'd0) begin
      $display("FAIL alarm_start_clear: alarm2=%b run2=%b sec2=%0d, required 0/0/0",
               alarm[2], running[2], secf(2));
      miscompares++;
    end
`endif
    pulse(2, 0, 0, 1, 0, 6'd0, 0);
    vectors++;
    if (alarm[2] !== 1'b1 || running[2] !== 1'b0) begin
      $display("FAIL alarm_zero_start: alarm2=%b run2=%b, required 1/0", alarm[2], running[2]);
      miscompares++;
    end
    pulse(2, 0, 1, 0, 0, 6'd5, 0);
    vectors++;
    if (alarm[2] !== 1'b0 || secf(2) !== 6'd5 || running[2] !== 1'b0) begin
      $display("FAIL alarm_load_clear: alarm2=%b sec2=%0d run2=%b, required 0/5/0",
               alarm[2], secf(2), running[2]);
      miscompares++;
    end
  endtask

  task automatic test_up_wrap;
    wait_tick; @(negedge clk);
    pulse(0, 1, 0, 0, 0, 6'd59, 0);
    pulse(0, 0, 1, 0, 0, 6'd58, 0);
    pulse(0, 0, 0, 1, 0, 6'd0, 1);
    vectors++;
    if (running !== 4'b0001) begin
      $display("FAIL up_start: running=%b, required 0001", running); miscompares++;
    end
    wait_tick; @(negedge clk);
    vectors++;
    if (minf(0) !== 6'd59 || secf(0) !== 6'd59) begin
      $display("FAIL up_5959: %0d:%0d, required 59:59", minf(0), secf(0)); miscompares++;
    end
    wait_tick; @(negedge clk);
    vectors++;
    if (minf(0) !== 6'd0 || secf(0) !== 6'd0 || running[0] !== 1'b1 || alarm[0] !== 1'b0) begin
      $display("FAIL up_wrap: %0d:%0d run0=%b alarm0=%b, required 0:0 1 0",
               minf(0), secf(0), running[0], alarm[0]);
      miscompares++;
    end
  endtask

  task automatic test_pause;
    wait_tick; @(negedge clk);
    pulse(1, 1, 0, 0, 0, 6'd5, 0);
    pulse(1, 0, 1, 0, 0, 6'd30, 0);
    pulse(1, 0, 0, 1, 0, 6'd0, 0);
    wait_tick; @(negedge clk);
    vectors++;
    if (minf(1) !== 6'd5 || secf(1) !== 6'd29) begin
      $display("FAIL pz_run: %0d:%0d, required 5:29", minf(1), secf(1)); miscompares++;
    end
    pulse(1, 0, 0, 0, 1, 6'd0, 0);
    vectors++;
    if (running[1] !== 1'b0) begin
      $display("FAIL pz_pause: run1=%b, required 0", running[1]); miscompares++;
    end
    repeat (5) begin
      wait_tick; @(negedge clk);
      vectors++;
      if (secf(1) !== 6'd29) begin
        $display("FAIL pz_frozen: sec1=%0d, required 29", secf(1)); miscompares++;
      end
    end
    pulse(1, 0, 0, 0, 1, 6'd0, 0);
    wait_tick; @(negedge clk);
    vectors++;
    if (secf(1) !== 6'd28 || running[1] !== 1'b1) begin
      $display("FAIL pz_resume: sec1=%0d run1=%b, required 28/1", secf(1), running[1]);
      miscompares++;
    end
    pulse(1, 1, 1, 0, 0, 6'd7, 0);
    vectors++;
    if (minf(1) !== 6'd5 || secf(1) !== 6'd28) begin
      $display("FAIL pz_load_in_run: %0d:%0d, required 5:28", minf(1), secf(1)); miscompares++;
    end
    wait_tick; @(negedge clk);
    vectors++;
    if (secf(1) !== 6'd27) begin
      $display("FAIL pz_count_after_load: sec1=%0d, required 27", secf(1)); miscompares++;
    end
    pulse(1, 0, 0, 0, 1, 6'd0, 0);
    pulse(1, 0, 1, 0, 0, 6'd63, 0);
    vectors++;
    if (secf(1) !== 6'd59 || minf(1) !== 6'd5) begin
      $display("FAIL pz_saturate: %0d:%0d, required 5:59", minf(1), secf(1)); miscompares++;
    end
    pulse(1, 1, 1, 0, 0, 6'd20, 0);
    vectors++;
    if (minf(1) !== 6'd20 || secf(1) !== 6'd20) begin
      $display("FAIL pz_dual_load: %0d:%0d, required 20:20", minf(1), secf(1)); miscompares++;
    end
  endtask

  task automatic test_same_cycle;
    wait_tick; @(negedge clk);
    pulse(3, 0, 1, 0, 0, 6'd10, 0);
    pulse(0, 0, 0, 0, 1, 6'd0, 0);
    pulse(0, 1, 0, 0, 0, 6'd10, 0);
    pulse(0, 0, 1, 0, 0, 6'd0, 0);
    pulse(0, 0, 0, 0, 1, 6'd0, 0);
    wait_tick;
    pulse(3, 0, 0, 1, 0, 6'd0, 1);
    vectors++;
    if (secf(3) !== 6'd10 || running[3] !== 1'b1) begin
      $display("FAIL sc_ch3_hold: sec3=%0d run3=%b, required 10/1", secf(3), running[3]);
      miscompares++;
    end
    vectors++;
    if (minf(0) !== 6'd10 || secf(0) !== 6'd1) begin
      $display("FAIL sc_ch0_adv: %0d:%0d, required 10:1", minf(0), secf(0)); miscompares++;
    end
    wait_tick; @(negedge clk);
    vectors++;
    if (secf(3) !== 6'd11 || secf(0) !== 6'd2) begin
      $display("FAIL sc_next: sec3=%0d sec0=%0d, required 11/2", secf(3), secf(0)); miscompares++;
    end
  endtask

  task automatic test_speed;
    int cyc;
    wait_tick; @(negedge clk);
    cmd_if.speed = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (tick !== 1'b1 && cyc < 30);
    vectors++;
    if (cyc != 2) begin
      $display("FAIL spd_fast_first: %0d cycles, required 2", cyc); miscompares++;
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (tick !== 1'b1 && cyc < 30);
    vectors++;
    if (cyc != 2) begin
      $display("FAIL spd_fast_period: %0d cycles, required 2", cyc); miscompares++;
    end
    cmd_if.speed = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (tick !== 1'b1 && cyc < 30);
    vectors++;
    if (cyc != 10) begin
      $display("FAIL spd_slow_first: %0d cycles, required 10", cyc); miscompares++;
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    rst = 1'b0;
    pulse(1, 0, 0, 1, 0, 6'd0, 0);
    vectors++;
    if (running !== '0 || alarm !== '0 || tick !== 1'b0) begin
      $display("FAIL rm_flags: run=%b alarm=%b tick=%b, required 0", running, alarm, tick);
      miscompares++;
    end
    vectors++;
    if (min_out !== '0 || sec_out !== '0) begin
      $display("FAIL rm_value: min=%h sec=%h, required 0", min_out, sec_out); miscompares++;
    end
    rst = 1'b1;
  endtask

  initial begin
    cmd_if.ch_sel   = '0;
    cmd_if.time_in  = '0;
    cmd_if.min_load = 1'b0;
    cmd_if.sec_load = 1'b0;
    cmd_if.start    = 1'b0;
    cmd_if.pause    = 1'b0;
    cmd_if.dir      = 1'b0;
    cmd_if.speed    = 1'b0;
    test_reset;
    test_down_count;
    test_alarm_hold;
    test_up_wrap;
    test_pause;
    test_same_cycle;
    test_speed;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_timer_core.md
# multi_timer_core

Parametrised, multi-channel successor to the single kitchen-timer datapath. It holds NUM_CH independent mm:ss timers (00:00–59:59), each with its own load, start, pause, direction and alarm state. A shared prescaler generates the count tick. The block sits between the debounced pushbutton/switch logic and the display integrator / VGA path, which consume the per-channel minute and second buses.

## Interface
Parameters:
- NUM_CH, 4: number of independent timer channels (1–16).
- TICK_DIV, 100_000_000: clk cycles per tick in normal speed (1 Hz at 100 MHz).
- FAST_DIV, 20_000_000: clk cycles per tick in fast speed (5 Hz).
- ALARM_TICKS, 10: ticks before alarm auto-clear; used only with TIMER_ALARM_TIMEOUT_EN.

Ports (CW = max(1, $clog2(NUM_CH))):
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset.
- ch_sel  in  CW  channel addressed by the command strobes; values ≥ NUM_CH are ignored.
- time_in  in  6  binary load value.
- min_load, sec_load, start, pause  in  1 each  single-cycle command strobes, already debounced.
- dir  in  1  0 = count down, 1 = count up; sampled on start.
- speed  in  1  0 = TICK_DIV, 1 = FAST_DIV.
- tick  out  1  one-cycle prescaler pulse.
- min_out, sec_out  out  6*NUM_CH each  channel n occupies [6n+5:6n].
- running  out  NUM_CH  channel in RUN.
- alarm  out  NUM_CH  channel in ALARM.

## Operation
- Prescaler: counter runs 0..DIV−1; tick = 1 in the cycle where counter == DIV−1. A change of speed restarts the counter at 0 on the next cycle.
- Per-channel FSM: IDLE, RUN, PAUSED, ALARM.
- Loads: min_load/sec_load write time_in, saturated to 59, into the minute/second field. Accepted in IDLE and PAUSED. In ALARM, a load clears alarm, goes to IDLE and writes the value. Ignored in RUN.
- start:
  - IDLE → RUN; latches dir.
  - If dir = 0 and the value is 00:00, go IDLE → ALARM instead.
  - ALARM → IDLE; the value is kept.
  - Ignored in RUN and PAUSED.
- pause: RUN → PAUSED, PAUSED → RUN. Ignored in IDLE and ALARM.
- On tick in RUN, up count: ss+1; at 59, ss = 0 and mm+1; 59:59 wraps to 00:00 and stays in RUN.
- On tick in RUN, down count: ss−1; at 0, ss = 59 and mm−1. Reaching 00:00 → ALARM.
- Priority within the same cycle for the addressed channel: load > start > pause > tick. A command to the selected channel suppresses that channel's tick advance in that cycle. Other channels advance normally.
- min_load and sec_load asserted together both write time_in.

## Timing
- All outputs are registered. A command or tick in cycle N is visible on the outputs in cycle N+1.
- Down count reaching 00:00 on the tick in cycle N: sec_out = 0 and alarm = 1 both appear at N+1.
- Reset (rst = 0 at a clk edge): prescaler = 0, tick = 0, all channels IDLE at 00:00, running = 0, alarm = 0, latched dir = 0.
- Reset wins over every command. Reset mid-run clears the channel with no alarm.
- Without the macro, alarm stays high until start or load.

## Configuration
- TIMER_ALARM_TIMEOUT_EN defined:
  - Each channel has a tick counter that starts on entry to ALARM.
  - After ALARM_TICKS ticks the channel auto-returns to IDLE at 00:00, and alarm drops the following cycle.
  - A start or load before the timeout behaves as normal.
- Undefined: no timeout logic is synthesised; alarm is held indefinitely.

## Test plan
Bench parameters: NUM_CH = 4, TICK_DIV = 10, FAST_DIV = 2.
- Reset: hold rst = 0 for 3 cycles → all min_out/sec_out = 0, running = 0, alarm = 0, tick = 0; tick first pulses 10 cycles after release.
- Down count on ch 2: load 0:03, start with dir = 0 → sec_out[17:12] steps 3,2,1,0 on successive ticks; alarm[2] = 1 the cycle after the 0 tick; other channels unchanged.
- Up-count wrap on ch 0: load 59:58, start with dir = 1 → 59:59 then 00:00, running[0] stays 1, alarm[0] = 0.
- Pause and ignored loads on ch 1: pause in RUN → value frozen over 5 ticks; load 7 in RUN is ignored; pause again → counting resumes; load of 63 while PAUSED → field = 59.
- Same-cycle events: start on ch 3 in a tick cycle → ch 3 does not advance that cycle; ch 0 running advances.
  - Speed toggle → next tick arrives 2 cycles later.
- With TIMER_ALARM_TIMEOUT_EN and ALARM_TICKS = 3: alarm clears 3 ticks after assertion.
  - Without the macro: alarm is still 1 after 20 ticks; start clears it.
